// File: rtl/fb_pkg.sv
// Shared types and helpers for the raytracer framebuffer writer.
package fb_pkg;

    // Default channel width of the scene colour triple.
    localparam int FB_CW = 8;

    // One pixel colour, r in the MSBs, matching the raytracer output packing.
    typedef struct packed {
        logic [FB_CW-1:0] r;
        logic [FB_CW-1:0] g;
        logic [FB_CW-1:0] b;
    } rgb_t;

    // Writer control states.
    typedef enum logic [1:0] {
        WRITE     = 2'd0,
        WAIT_SWAP = 2'd1,
        SWAP      = 2'd2
    } fw_state_t;

    // Raster-order linear address of pixel (x,y) in a frame of the given width.
    function automatic int unsigned pix_addr(input int unsigned x,
                                             input int unsigned y,
                                             input int unsigned width);
        return y * width + x;
    endfunction

endpackage

// File: rtl/fb_bank.sv
// One framebuffer bank: single write port, single registered read port.
module fb_bank #(
    parameter int DEPTH = 3072,
    parameter int AW    = 12,
    parameter int DW    = 24
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Pixel store; contents survive reset on purpose.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; the caller only enables it for in-range addresses.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_writer.sv
// Ping-pong framebuffer writer: fills the back bank from the raster pixel
// stream, swaps banks at frame end (held off by rd_busy) and serves the
// front bank through a registered read port.
module frame_writer
    import fb_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 48,
    parameter int CW     = 8,
    parameter int FCW    = 16,
    localparam int AW    = $clog2(WIDTH * HEIGHT)
) (
    input  logic            sysclk,
    input  logic            rst,
    input  logic            pix_valid,
    output logic            pix_ready,
    input  logic            pix_sof,
    input  logic [3*CW-1:0] pix_rgb,
    input  logic [AW-1:0]   rd_addr,
    output logic [3*CW-1:0] rd_data,
    input  logic            rd_busy,
    output logic            update,
    output logic            front_sel,
    output logic [FCW-1:0]  frame_count,
    output logic            sof_err
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int DW   = 3 * CW;
    localparam int XW   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [AW:0]   NPIX_W = (AW + 1)'(NPIX);

    fw_state_t       state_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic            ready_q;
    logic            update_q;
    logic            front_q;
    logic [FCW-1:0]  fcnt_q;
    logic            sof_err_q;
    logic            rd_sel_q;
    logic            rd_ok_q;

    logic            accept;
    logic            at_origin;
    logic            last_pix;
    logic [AW-1:0]   wr_addr;
    logic            rd_in_range;
    logic [1:0]      bank_we;
    logic [1:0]      bank_re;
    logic [DW-1:0]   bank_rdata [2];

    assign accept      = pix_valid && ready_q;
    assign at_origin   = (x_q == '0) && (y_q == '0);
    assign last_pix    = (x_q == X_LAST) && (y_q == Y_LAST);
    // A start-of-frame pixel always restarts the raster at address 0.
    assign wr_addr     = pix_sof ? '0
                                 : AW'(pix_addr(32'(x_q), 32'(y_q), WIDTH));
    assign rd_in_range = {1'b0, rd_addr} < NPIX_W;

    // Raster counters, frame FSM and all registered status outputs.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q   <= WRITE;
            x_q       <= '0;
            y_q       <= '0;
            ready_q   <= 1'b0;
            update_q  <= 1'b0;
            front_q   <= 1'b0;
            fcnt_q    <= '0;
            sof_err_q <= 1'b0;
        end else begin
            update_q  <= 1'b0;
            sof_err_q <= 1'b0;
            case (state_q)
                WRITE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (pix_sof) begin
                            // sof takes priority, even over the last pixel slot
                            x_q       <= XW'(1);
                            y_q       <= '0;
                            sof_err_q <= !at_origin;
                        end else if (last_pix) begin
                            x_q     <= '0;
                            y_q     <= '0;
                            ready_q <= 1'b0;
                            state_q <= WAIT_SWAP;
                        end else if (x_q == X_LAST) begin
                            x_q <= '0;
                            y_q <= y_q + 1'b1;
                        end else begin
                            x_q <= x_q + 1'b1;
                        end
                    end
                end
                WAIT_SWAP: begin
                    if (!rd_busy) begin
                        front_q  <= ~front_q;
                        update_q <= 1'b1;
                        fcnt_q   <= fcnt_q + 1'b1;
                        state_q  <= SWAP;
                    end
                end
                SWAP: begin
                    ready_q <= 1'b1;
                    state_q <= WRITE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= WRITE;
                end
            endcase
        end
    end

    // Read-side bookkeeping: bank and range are captured with the address so
    // the returned data reflects front_sel at sampling time.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            rd_sel_q <= 1'b0;
            rd_ok_q  <= 1'b0;
        end else begin
            rd_sel_q <= front_q;
            rd_ok_q  <= rd_in_range;
        end
    end

    // Bank b is written while it is the back buffer and read while it is the
    // front one, so the two ports never meet on the same bank.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b] = accept && (front_q != 1'(b));
        assign bank_re[b] = rd_in_range && (front_q == 1'(b));

        fb_bank #(
            .DEPTH (NPIX),
            .AW    (AW),
            .DW    (DW)
        ) u_bank (
            .clk_i   (sysclk),
            .we_i    (bank_we[b]),
            .waddr_i (wr_addr),
            .wdata_i (pix_rgb),
            .re_i    (bank_re[b]),
            .raddr_i (rd_addr),
            .rdata_o (bank_rdata[b])
        );
    end

    assign rd_data     = rd_ok_q ? bank_rdata[rd_sel_q] : '0;
    assign pix_ready   = ready_q;
    assign update      = update_q;
    assign front_sel   = front_q;
    assign frame_count = fcnt_q;
    assign sof_err     = sof_err_q;

endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer (4x2 main instance, 3x2 instance for
// out-of-range reads).
module tb_frame_writer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 3;

    logic        sysclk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic        pix_sof = 1'b0;
    logic [23:0] pix_rgb = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [23:0] rd_data;
    logic        rd_busy = 1'b0;
    logic        update;
    logic        front_sel;
    logic [15:0] frame_count;
    logic        sof_err;

    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [2:0]  b_rd_addr = '0;
    logic [23:0] b_rd_data;
    logic        b_update;
    logic        b_front_sel;
    logic [15:0] b_frame_count;
    logic        b_sof_err;

    always #5 sysclk = ~sysclk;

    frame_writer #(.WIDTH(W), .HEIGHT(H), .CW(8), .FCW(16)) dut (
        .sysclk(sysclk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_rgb(pix_rgb), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .update(update), .front_sel(front_sel),
        .frame_count(frame_count), .sof_err(sof_err)
    );

    frame_writer #(.WIDTH(3), .HEIGHT(2), .CW(8), .FCW(16)) dut_b (
        .sysclk(sysclk), .rst(rst), .pix_valid(b_valid), .pix_ready(b_ready),
        .pix_sof(pix_sof), .pix_rgb(pix_rgb), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_busy(1'b0), .update(b_update), .front_sel(b_front_sel),
        .frame_count(b_frame_count), .sof_err(b_sof_err)
    );

    typedef struct { int c; int fs; int fc; } upd_t;

    upd_t        q_upd[$];
    int          q_sof[$];
    logic [23:0] q_rd[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_acc = 0;
    logic        rd_chk = 1'b0;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Frame strobe and sof_err monitor.
    always @(negedge sysclk) begin
        upd_t e;
        int   sc;
        if (update !== 1'b0) begin
            if (q_upd.size() == 0) fail_now("update_unexpected_at_cycle", cyc, -1);
            else begin
                e = q_upd.pop_front();
                chk("update_cycle", cyc, e.c);
                chk("front_sel", front_sel, e.fs);
                chk("frame_count", frame_count, e.fc);
            end
        end
        if (sof_err !== 1'b0) begin
            if (q_sof.size() == 0) fail_now("sof_err_unexpected_at_cycle", cyc, -1);
            else begin
                sc = q_sof.pop_front();
                chk("sof_err_cycle", cyc, sc);
            end
        end
    end

    // Read-data monitor: one cycle after an issued read.
    always begin
        @(posedge sysclk);
        if (rd_chk) begin
            #1;
            if (q_rd.size() == 0) fail_now("rd_unexpected", 0, 1);
            else chk("rd_data", rd_data, q_rd.pop_front());
        end
    end

    task automatic send(input logic [23:0] rgb, input logic sof);
        int t = 0;
        pix_valid = 1'b1;
        pix_rgb   = rgb;
        pix_sof   = sof;
        while (pix_ready !== 1'b1 && t < 50) begin
            @(negedge sysclk);
            t++;
        end
        if (t >= 50) fail_now("send_timeout", t, 0);
        last_acc = cyc;
        @(negedge sysclk);
    endtask

    task automatic stop();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic expect_swap(input int fs, input int fc);
        q_upd.push_back('{last_acc + 2, fs, fc});
    endtask

    task automatic rd_issue(input logic [AW-1:0] a, input logic [23:0] e);
        rd_addr = a;
        rd_chk  = 1'b1;
        q_rd.push_back(e);
        @(negedge sysclk);
        rd_chk  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // reset state
        idle(3);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_update", update, 0);
        chk("rst_front_sel", front_sel, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_sof_err", sof_err, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        idle(1);
        chk("ready_after_rst", pix_ready, 1);

        // frame 1: rgb=i, back-to-back, rd_busy low
        for (int i = 0; i < 8; i++) send(24'(i), i == 0);
        stop();
        expect_swap(1, 1);
        chk("ready_low_n1", pix_ready, 0);
        idle(1);
        chk("ready_low_n2", pix_ready, 0);
        idle(1);
        chk("ready_back_n3", pix_ready, 1);
        for (int a = 0; a < 8; a++) rd_issue(3'(a), 24'(a));

        // frame 2: constant colour, swap held off by rd_busy
        for (int i = 0; i < 8; i++) begin
            if (i == 7) rd_busy = 1'b1;
            send(24'h0096FA, i == 0);
        end
        stop();
        q_upd.push_back('{last_acc + 7, 0, 2});
        for (int k = 0; k < 5; k++) begin
            chk("ready_while_busy", pix_ready, 0);
            idle(1);
        end
        rd_busy = 1'b0;
        rd_issue(3'd2, 24'd2);          // sampled on the swap edge: old front
        rd_issue(3'd5, 24'h0096FA);     // sampled while update is high: new front
        idle(2);
        chk("ready_after_busy_swap", pix_ready, 1);
        for (int a = 0; a < 8; a++) rd_issue(3'(a), 24'h0096FA);

        // frame 3: pix_valid every other cycle
        for (int i = 0; i < 8; i++) begin
            send(24'h000100 + 24'(i), i == 0);
            stop();
            if (i != 7) idle(1);
        end
        expect_swap(1, 3);
        idle(3);
        for (int a = 0; a < 8; a++) rd_issue(3'(a), 24'h000100 + 24'(a));

        // frame 4: sof on the 5th pixel restarts the raster
        for (int i = 0; i < 4; i++) send(24'h000400 + 24'(i), i == 0);
        q_sof.push_back(cyc + 1);
        send(24'hAA0000, 1'b1);
        for (int k = 1; k < 8; k++) send(24'h000500 + 24'(k), 1'b0);
        stop();
        expect_swap(0, 4);
        idle(3);
        rd_issue(3'd0, 24'hAA0000);
        for (int a = 1; a < 8; a++) rd_issue(3'(a), 24'h000500 + 24'(a));

        // reset mid-frame after 3 pixels
        for (int i = 0; i < 3; i++) send(24'h000600 + 24'(i), i == 0);
        stop();
        rst = 1'b1;
        idle(1);
        chk("mid_rst_pix_ready", pix_ready, 0);
        chk("mid_rst_update", update, 0);
        chk("mid_rst_front_sel", front_sel, 0);
        chk("mid_rst_frame_count", frame_count, 0);
        chk("mid_rst_sof_err", sof_err, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        rst = 1'b0;
        idle(1);
        chk("ready_after_mid_rst", pix_ready, 1);
        // fresh frame, first pixel without sof
        for (int i = 0; i < 8; i++) send(24'h000700 + 24'(i), 1'b0);
        stop();
        expect_swap(1, 1);
        idle(3);
        for (int a = 0; a < 8; a++) rd_issue(3'(a), 24'h000700 + 24'(a));

        // 3x2 instance: addresses 6 and 7 lie past the frame
        for (int i = 0; i < 6; i++) begin
            b_valid = 1'b1;
            pix_rgb = 24'h000800 + 24'(i);
            pix_sof = (i == 0);
            t = 0;
            while (b_ready !== 1'b1 && t < 50) begin
                @(negedge sysclk);
                t++;
            end
            if (t >= 50) fail_now("b_send_timeout", t, 0);
            @(negedge sysclk);
        end
        b_valid = 1'b0;
        pix_sof = 1'b0;
        idle(4);
        chk("b_front_sel", b_front_sel, 1);
        chk("b_frame_count", b_frame_count, 1);
        b_rd_addr = 3'd5;
        idle(1);
        chk("b_rd_last_pixel", b_rd_data, 24'h000805);
        b_rd_addr = 3'd6;
        idle(1);
        chk("b_rd_out_of_range6", b_rd_data, 0);
        b_rd_addr = 3'd7;
        idle(1);
        chk("b_rd_out_of_range7", b_rd_data, 0);

        idle(3);
        if (q_upd.size() != 0) fail_now("missing_updates", 0, q_upd.size());
        if (q_sof.size() != 0) fail_now("missing_sof_err", 0, q_sof.size());
        if (q_rd.size() != 0) fail_now("missing_reads", 0, q_rd.size());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
